// File: rtl/tlb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tlb_ctrl
//  Description : Sequencer for TLBSRCH / TLBRD / TLBWR / TLBFILL / INVTLB.
//                Accepts one instruction at a time, drives the TLB write,
//                read and invtlb ports, time-shares search port 1 with
//                load/store lookups and returns a one-cycle response pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tlb_ctrl #(
  parameter int  TLBNUM    = 16,
  parameter int  MAX_STALL = 8,
  localparam int IDXW      = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [4:0]      req_inv_op,
  input  logic [9:0]      req_inv_asid,
  input  logic [18:0]     req_inv_vppn,
  input  logic [IDXW-1:0] csr_index,
  input  logic            csr_ne,
  input  logic [18:0]     csr_vppn,
  input  logic [9:0]      csr_asid,
  input  logic            flush,
  input  logic            mem_lookup_valid,
  output logic            mem_stall,
  output logic            s1_sel,
  output logic [18:0]     s1_vppn_o,
  output logic [9:0]      s1_asid_o,
  input  logic            s1_found,
  input  logic [IDXW-1:0] s1_index,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic            tlb_w_e,
  output logic [IDXW-1:0] tlb_r_index,
  output logic            invtlb_valid,
  output logic [4:0]      invtlb_op,
  output logic            rsp_valid,
  output logic [2:0]      rsp_op,
  output logic            rsp_found,
  output logic [IDXW-1:0] rsp_index,
  output logic            rsp_err
);

  localparam int SCW = $clog2(MAX_STALL + 1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_EXEC = 2'd1;
  localparam logic [1:0] c_ST_RSP  = 2'd2;

  localparam logic [2:0] c_OP_SRCH = 3'd0;
  localparam logic [2:0] c_OP_RD   = 3'd1;
  localparam logic [2:0] c_OP_WR   = 3'd2;
  localparam logic [2:0] c_OP_FILL = 3'd3;
  localparam logic [2:0] c_OP_INV  = 3'd4;

  localparam logic [SCW-1:0]  c_MAX_STALL = SCW'(MAX_STALL);
  localparam logic [IDXW-1:0] c_FILL_LAST = IDXW'(TLBNUM - 1);

  logic [1:0]      r_state;
  logic [2:0]      r_op;
  logic [4:0]      r_inv_op;
  logic [9:0]      r_inv_asid;
  logic [18:0]     r_inv_vppn;
  logic [IDXW-1:0] r_index;
  logic            r_ne;
  logic [18:0]     r_vppn;
  logic [9:0]      r_asid;
  logic [IDXW-1:0] r_fill_idx;
  logic [IDXW-1:0] r_fill_cnt;
  logic [SCW-1:0]  r_stall_cnt;
  logic            r_found;
  logic [IDXW-1:0] r_hit_index;

  logic w_accept;
  logic w_in_exec;
  logic w_in_rsp;
  logic w_inv_bad;
  logic w_port_op;
  logic w_yield;
  logic w_take;
  logic w_write_op;

  assign w_in_exec  = (r_state == c_ST_EXEC);
  assign w_in_rsp   = (r_state == c_ST_RSP);
  assign req_ready  = (r_state == c_ST_IDLE) && !flush;
  assign w_accept   = req_valid && req_ready;
  assign w_inv_bad  = (r_inv_op > 5'd6);
  // Only SRCH and a legal INVTLB need search port 1
  assign w_port_op  = w_in_exec &&
                      ((r_op == c_OP_SRCH) || ((r_op == c_OP_INV) && !w_inv_bad));
  // Load/store keeps the port until the stall budget is used up
  assign w_yield    = w_port_op && mem_lookup_valid && (r_stall_cnt < c_MAX_STALL);
  assign w_take     = w_port_op && !w_yield;
  assign w_write_op = w_in_exec && ((r_op == c_OP_WR) || (r_op == c_OP_FILL));

  assign s1_sel       = w_take;
  assign mem_stall    = w_take && mem_lookup_valid;
  assign s1_vppn_o    = !w_take ? 19'd0 : ((r_op == c_OP_SRCH) ? r_vppn : r_inv_vppn);
  assign s1_asid_o    = !w_take ? 10'd0 : ((r_op == c_OP_SRCH) ? r_asid : r_inv_asid);
  assign invtlb_valid = w_take && (r_op == c_OP_INV);
  assign invtlb_op    = invtlb_valid ? r_inv_op : 5'd0;

  assign tlb_we      = w_write_op;
  assign tlb_w_index = !w_write_op ? '0 : ((r_op == c_OP_WR) ? r_index : r_fill_idx);
  assign tlb_w_e     = w_write_op && !r_ne;
  assign tlb_r_index = ((w_in_exec || w_in_rsp) && (r_op == c_OP_RD)) ? r_index : '0;

  assign rsp_valid = w_in_rsp;
  assign rsp_op    = w_in_rsp ? r_op : 3'd0;
  assign rsp_found = w_in_rsp && r_found;
  assign rsp_index = w_in_rsp ? r_hit_index : '0;
  assign rsp_err   = w_in_rsp && (r_op == c_OP_INV) && w_inv_bad;

  // Free-running FILL victim counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fill_cnt <= '0;
    end else if (r_fill_cnt == c_FILL_LAST) begin
      r_fill_cnt <= '0;
    end else begin
      r_fill_cnt <= r_fill_cnt + 1'b1;
    end
  end

  // Sequencer state and port-arbitration stall counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= c_ST_IDLE;
      r_stall_cnt <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            r_state <= c_ST_EXEC;
          end
        end
        c_ST_EXEC: begin
          if (w_yield) begin
            if (flush) begin
              r_state     <= c_ST_IDLE;
              r_stall_cnt <= '0;
            end else begin
              r_stall_cnt <= r_stall_cnt + 1'b1;
            end
          end else begin
            r_stall_cnt <= '0;
            r_state     <= c_ST_RSP;
          end
        end
        c_ST_RSP: r_state <= c_ST_IDLE;
        default:  r_state <= c_ST_IDLE;
      endcase
    end
  end

  // Snapshot of the instruction and its CSR operands at acceptance
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_op       <= '0;
      r_inv_op   <= '0;
      r_inv_asid <= '0;
      r_inv_vppn <= '0;
      r_index    <= '0;
      r_ne       <= 1'b0;
      r_vppn     <= '0;
      r_asid     <= '0;
      r_fill_idx <= '0;
    end else if (w_accept) begin
      r_op       <= req_op;
      r_inv_op   <= req_inv_op;
      r_inv_asid <= req_inv_asid;
      r_inv_vppn <= req_inv_vppn;
      r_index    <= csr_index;
      r_ne       <= csr_ne;
      r_vppn     <= csr_vppn;
      r_asid     <= csr_asid;
      r_fill_idx <= r_fill_cnt;
    end
  end

  // Search result capture; cleared per instruction so non-SRCH ops report 0
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_found     <= 1'b0;
      r_hit_index <= '0;
    end else if (w_accept) begin
      r_found     <= 1'b0;
      r_hit_index <= '0;
    end else if (w_take && (r_op == c_OP_SRCH)) begin
      r_found     <= s1_found;
      r_hit_index <= s1_index;
    end
  end

endmodule
`default_nettype wire
